// File: rtl/nv_fifo_256x8_ctrl.sv
// rtl/nv_fifo_256x8_ctrl.sv - 258-deep x 8 valid/ready FIFO controller for a 256x8 registered-read RAM
//
// Ports:
//   nvdla_core_clk, nvdla_core_rstn   clock, asynchronous active-low reset
//   wr_pvld / wr_prdy / wr_pd         producer side (wr_prdy is registered)
//   rd_pvld / rd_prdy / rd_pd         consumer side, head of the 2-entry output stage
//   ram_wa / ram_we / ram_di          RAM write port
//   ram_ra / ram_re / ram_dout        RAM read port, dout valid the cycle after ram_re
//   fifo_cnt                          entries held: RAM + in-flight read + output stage
//
// Build option: define NV_FIFO_CTRL_BYPASS_EN to let pushes into an otherwise
// empty pipeline go straight to the output stage (1-cycle empty latency).

module nv_fifo_256x8_ctrl (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic       wr_pvld,
  output logic       wr_prdy,
  input  logic [7:0] wr_pd,
  output logic       rd_pvld,
  input  logic       rd_prdy,
  output logic [7:0] rd_pd,
  output logic [7:0] ram_wa,
  output logic       ram_we,
  output logic [7:0] ram_di,
  output logic [7:0] ram_ra,
  output logic       ram_re,
  input  logic [7:0] ram_dout,
  output logic [9:0] fifo_cnt
);

  logic [7:0] wr_adr;
  logic [7:0] rd_adr;
  logic [8:0] ram_cnt;
  logic [8:0] ram_cnt_next;
  logic       inflight;
  logic [1:0] out_cnt;
  logic [1:0] out_cnt_next;
  logic [1:0] keep_cnt;
  logic [7:0] head;
  logic [7:0] tail;
  logic       push;
  logic       pop;
  logic       bypass;
  logic       cap_vld;
  logic [7:0] cap_data;

  assign rd_pvld  = (out_cnt != 2'd0);
  assign rd_pd    = head;
  assign ram_wa   = wr_adr;
  assign ram_ra   = rd_adr;
  assign fifo_cnt = {1'b0, ram_cnt} + {9'd0, inflight} + {8'd0, out_cnt};

  always_comb begin
    push     = wr_pvld & wr_prdy;
    pop      = rd_pvld & rd_prdy;
    // Occupancy of the output stage once this cycle's pop has left it.
    keep_cnt = out_cnt - {1'b0, pop};
`ifdef NV_FIFO_CTRL_BYPASS_EN
    // Safe only when nothing older is in the RAM or on its read port.
    bypass   = push & (ram_cnt == 9'd0) & ~inflight & (keep_cnt != 2'd2);
`else
    bypass   = 1'b0;
`endif
    // Registered ram_cnt: a word written this cycle is never read this cycle,
    // so the macro's read/write bypass is never relied upon.
    ram_re       = (ram_cnt != 9'd0) & ((keep_cnt + {1'b0, inflight}) < 2'd2);
    ram_we       = push & ~bypass;
    ram_di       = ram_we ? wr_pd : 8'd0;
    ram_cnt_next = ram_cnt + {8'd0, ram_we} - {8'd0, ram_re};
    // inflight and bypass are mutually exclusive by construction.
    cap_vld      = inflight | bypass;
    cap_data     = inflight ? ram_dout : wr_pd;
    out_cnt_next = keep_cnt + {1'b0, cap_vld};
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_adr   <= 8'd0;
      rd_adr   <= 8'd0;
      ram_cnt  <= 9'd0;
      inflight <= 1'b0;
      out_cnt  <= 2'd0;
      head     <= 8'd0;
      tail     <= 8'd0;
      wr_prdy  <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_adr <= wr_adr + 8'd1;
      end
      if (ram_re) begin
        rd_adr <= rd_adr + 8'd1;
      end
      ram_cnt  <= ram_cnt_next;
      inflight <= ram_re;
      wr_prdy  <= (ram_cnt_next != 9'd256);
      out_cnt  <= out_cnt_next;
      // Incoming word lands in the first slot free after the pop; ram_dout is
      // sampled on this edge only.
      if (cap_vld && (keep_cnt == 2'd0)) begin
        head <= cap_data;
      end else if (pop) begin
        head <= tail;
      end
      if (cap_vld && (keep_cnt == 2'd1)) begin
        tail <= cap_data;
      end
    end
  end

endmodule

// File: tb/tb_nv_fifo_256x8_ctrl.sv
// tb/tb_nv_fifo_256x8_ctrl.sv - self-checking bench for nv_fifo_256x8_ctrl with a behavioural RAM macro
module tb_nv_fifo_256x8_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_pvld;
  logic       wr_prdy;
  logic [7:0] wr_pd;
  logic       rd_pvld;
  logic       rd_prdy;
  logic [7:0] rd_pd;
  logic [7:0] ram_wa;
  logic       ram_we;
  logic [7:0] ram_di;
  logic [7:0] ram_ra;
  logic       ram_re;
  logic [7:0] ram_dout;
  logic [9:0] fifo_cnt;

  always #5 clk = ~clk;

  nv_fifo_256x8_ctrl dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_dout        (ram_dout),
    .fifo_cnt        (fifo_cnt)
  );

  // 256x8 macro: registered read, dout held until the next re, no bypass.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of accepted bytes plus RAM access counts.
  logic [7:0] sb[$];
  int  wr_seen;
  int  rd_seen;
  bit  skip_prdy;
  bit  last_push;
  bit  last_pop;
  logic [7:0] exp_pd;

  task automatic model();
    chk("fifo_cnt", int'(fifo_cnt), sb.size());
    if (sb.size() == 0) chk("rd_pvld_empty", int'(rd_pvld), 0);
    if (!skip_prdy && sb.size() < 256) chk("wr_prdy_room", int'(wr_prdy), 1);
    if (sb.size() == 258) chk("wr_prdy_full", int'(wr_prdy), 0);
    chk("rw_collision", int'(ram_re && ram_we && (ram_ra == ram_wa)), 0);
    if (ram_we) begin
      chk("ram_wa", int'(ram_wa), wr_seen % 256);
      chk("ram_di", int'(ram_di), int'(wr_pd));
      wr_seen++;
    end
    if (ram_re) begin
      chk("ram_ra", int'(ram_ra), rd_seen % 256);
      rd_seen++;
    end
    last_pop  = rd_pvld && rd_prdy;
    last_push = wr_pvld && wr_prdy;
    if (last_pop) begin
      chk("pop_nonempty", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_pd = sb.pop_front();
        chk("rd_pd_order", int'(rd_pd), int'(exp_pd));
      end
    end
    if (last_push) sb.push_back(wr_pd);
    skip_prdy = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    wr_pvld = 1'b1;
    wr_pd   = 8'hFF;
    rd_prdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_prdy", int'(wr_prdy), 0);
    chk("rst_rd_pvld", int'(rd_pvld), 0);
    chk("rst_rd_pd", int'(rd_pd), 0);
    chk("rst_fifo_cnt", int'(fifo_cnt), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_re", int'(ram_re), 0);
    chk("rst_ram_wa", int'(ram_wa), 0);
    chk("rst_ram_ra", int'(ram_ra), 0);
    chk("rst_ram_di", int'(ram_di), 0);
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    wr_pvld   = 1'b0;
    wr_pd     = 8'h00;
    rd_prdy   = 1'b0;
    sb.delete();
    wr_seen   = 0;
    rd_seen   = 0;
    skip_prdy = 1;
  endtask

  task automatic drain(input int bound);
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int c = 0; c < bound && sb.size() != 0; c++) cycle();
    chk("drained", sb.size(), 0);
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       e_wprdy;
    logic       e_rpvld;
    logic [7:0] e_rpd;
    logic       e_we;
    logic       e_re;
    logic [7:0] e_wa;
    logic [7:0] e_ra;
    logic [9:0] e_cnt;
  } vec_t;

  vec_t vt [0:5];
  int   pushed;
  int   steady_cnt;
  bit   seen_re;
  bit   prdy_checked;
  bit   got;

  initial begin
    rstn = 1'b0; wr_pvld = 1'b0; wr_pd = 8'h00; rd_prdy = 1'b0;

    // Single push of 0xA5 right after reset release; row 0 is the first cycle out of reset.
`ifdef NV_FIFO_CTRL_BYPASS_EN
    vt[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0};
    vt[1] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd0, 8'd0, 10'd1};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0};
`else
    vt[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0, 10'd0};
    vt[1] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'd0, 10'd0};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1, 8'd0, 10'd1};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 8'd1, 10'd1};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd1, 8'd1, 10'd1};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 8'd1, 10'd0};
`endif

    do_reset();

    for (int r = 0; r < 6; r++) begin
      wr_pvld = vt[r].wv;
      wr_pd   = vt[r].wd;
      rd_prdy = vt[r].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_wr_prdy", r), int'(wr_prdy), int'(vt[r].e_wprdy));
      chk($sformatf("vec%0d_rd_pvld", r), int'(rd_pvld), int'(vt[r].e_rpvld));
      if (vt[r].e_rpvld) chk($sformatf("vec%0d_rd_pd", r), int'(rd_pd), int'(vt[r].e_rpd));
      chk($sformatf("vec%0d_ram_we", r), int'(ram_we), int'(vt[r].e_we));
      chk($sformatf("vec%0d_ram_re", r), int'(ram_re), int'(vt[r].e_re));
      chk($sformatf("vec%0d_ram_wa", r), int'(ram_wa), int'(vt[r].e_wa));
      chk($sformatf("vec%0d_ram_ra", r), int'(ram_ra), int'(vt[r].e_ra));
      chk($sformatf("vec%0d_fifo_cnt", r), int'(fifo_cnt), int'(vt[r].e_cnt));
      model();
      @(posedge clk);
      #1;
    end

    // Fill to capacity with 0..257 mod 256 while the consumer stalls.
    rd_prdy = 1'b0;
    pushed  = 0;
    for (int c = 0; c < 600 && pushed < 258; c++) begin
      wr_pvld = 1'b1;
      wr_pd   = 8'(pushed);
      @(negedge clk);
      model();
      if (last_push) pushed++;
      @(posedge clk);
      #1;
    end
    chk("fill_count", pushed, 258);
    wr_pd = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_wr_prdy", int'(wr_prdy), 0);
      chk("full_fifo_cnt", int'(fifo_cnt), 258);
      model();
      chk("no_259th_push", int'(last_push), 0);
      @(posedge clk);
      #1;
    end

    // Drain; wr_prdy must come back the cycle after the first RAM read.
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    seen_re = 0;
    prdy_checked = 0;
    for (int c = 0; c < 700 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (seen_re && !prdy_checked) begin
        chk("wr_prdy_after_first_read", int'(wr_prdy), 1);
        prdy_checked = 1;
      end
      if (!seen_re && ram_re) begin
        chk("wr_prdy_at_first_read", int'(wr_prdy), 0);
        seen_re = 1;
      end
      model();
      @(posedge clk);
      #1;
    end
    chk("full_drained", sb.size(), 0);
    chk("full_drain_read_seen", int'(prdy_checked), 1);

    // Continuous streaming: once primed, every cycle pushes and pops.
`ifdef NV_FIFO_CTRL_BYPASS_EN
    steady_cnt = 1;
`else
    steady_cnt = 3;
`endif
    wr_pvld = 1'b1;
    rd_prdy = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      wr_pd = 8'($urandom);
      @(negedge clk);
      if (c >= 10) begin
        chk("stream_no_gap", int'({wr_prdy, rd_pvld}), 3);
        chk("stream_cnt_const", int'(fifo_cnt), steady_cnt);
      end
      model();
      @(posedge clk);
      #1;
    end
`ifndef NV_FIFO_CTRL_BYPASS_EN
    chk("stream_ptr_wrapped", int'(wr_seen > 512), 1);
`endif
    drain(20);

    // Random handshakes on both sides.
    for (int c = 0; c < 3000; c++) begin
      wr_pvld = 1'($urandom);
      rd_prdy = 1'($urandom);
      wr_pd   = 8'($urandom);
      cycle();
    end
    drain(300);

    // Reset mid-operation with 100 entries held.
    rd_prdy = 1'b0;
    for (int c = 0; c < 300 && sb.size() < 100; c++) begin
      wr_pvld = 1'b1;
      wr_pd   = 8'($urandom);
      cycle();
    end
    wr_pvld = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    chk("pre_reset_cnt", int'(fifo_cnt), 100);
    rstn    = 1'b0;
    wr_pvld = 1'b1;
    #1;
    chk("async_rst_fifo_cnt", int'(fifo_cnt), 0);
    chk("async_rst_rd_pvld", int'(rd_pvld), 0);
    chk("async_rst_wr_prdy", int'(wr_prdy), 0);
    chk("async_rst_ram_re", int'(ram_re), 0);
    chk("async_rst_ram_we", int'(ram_we), 0);
    chk("async_rst_rd_pd", int'(rd_pd), 0);
    do_reset();
    wr_pvld = 1'b1;
    wr_pd   = 8'h3C;
    for (int c = 0; c < 5 && sb.size() == 0; c++) cycle();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rd_pvld) begin
        chk("first_after_reset", int'(rd_pd), 8'h3C);
        got = 1;
      end
      model();
      @(posedge clk);
      #1;
    end
    chk("popped_after_reset", int'(got), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nv_fifo_256x8_ctrl.md
# nv_fifo_256x8_ctrl

Client-side controller for the 256x8 registered-read dual-port RAM macro (read latency 1, `dout` held until the next `re`). It drives the RAM write port and read port and turns the macro into a 258-deep, 8-bit valid/ready FIFO. Writes go to the RAM. Reads are prefetched into a 2-entry output stage. The block sits between producer and consumer pipes in NVDLA core datapaths, with the RAM instanced beside it.

## Interface
Parameters: none. Depth 256 and width 8 are fixed by the macro.

Ports:
- `nvdla_core_clk`  in  1  single clock; all state on its rising edge
- `nvdla_core_rstn`  in  1  reset, asynchronous assert, active-low
- `wr_pvld`  in  1  producer data valid
- `wr_prdy`  out  1  FIFO can accept; registered
- `wr_pd`  in  8  producer data
- `rd_pvld`  out  1  output stage head valid
- `rd_prdy`  in  1  consumer ready
- `rd_pd`  out  8  output stage head data
- `ram_wa`  out  8  RAM write address
- `ram_we`  out  1  RAM write enable
- `ram_di`  out  8  RAM write data
- `ram_ra`  out  8  RAM read address
- `ram_re`  out  1  RAM read enable
- `ram_dout`  in  8  RAM read data, valid the cycle after `ram_re`
- `fifo_cnt`  out  10  total entries held (RAM + in-flight + output stage), 0..258

## Operation
- State:
  - `wr_adr[7:0]` and `rd_adr[7:0]`, both wrapping 255→0.
  - `ram_cnt[8:0]`, range 0..256.
  - `inflight`: a read was issued last cycle.
  - Output stage of 2 entries (head, tail), with `out_cnt` 0..2.
- Push: `push = wr_pvld & wr_prdy`.
  - `ram_we = push`, `ram_wa = wr_adr`, `ram_di = wr_pd`.
  - `wr_adr` increments on push.
- Pop: `pop = rd_pvld & rd_prdy`.
  - Head is removed and the tail shifts to the head.
- Read issue, combinational:
  - `ram_re = (ram_cnt != 0) & (out_cnt + inflight - pop < 2)`.
  - `ram_ra = rd_adr`; `rd_adr` increments on `ram_re`.
  - `ram_cnt` uses the registered value, so a push in the same cycle is never readable. The controller never reads an address it is writing in that cycle, so it does not depend on the macro's write/read bypass.
- Capture:
  - When `inflight=1`, `ram_dout` is written into the first free output slot at the end of that cycle, after accounting for a same-cycle pop.
  - The data is captured on that edge only. Once the entry is freed the RAM location may be overwritten, so `ram_dout` is never sampled later.
- `ram_cnt_next = ram_cnt + push - ram_re`.
- `wr_prdy_next = (ram_cnt_next != 256)`.
- `fifo_cnt = ram_cnt + inflight + out_cnt`.
- Ordering is strict FIFO. There is no drop and no duplication.

## Timing
- Reset values:
  - `wr_prdy=0`, `rd_pvld=0`, `rd_pd=0`, `fifo_cnt=0`.
  - `ram_we=0`, `ram_re=0`, `ram_wa=0`, `ram_ra=0`, `ram_di=0`.
  - All pointers and counts are 0.
- `wr_prdy` rises on the first clock edge after reset is released.
- Reset asserted mid-operation: all contents are discarded and the RAM array is left as is.
- Latency, empty FIFO, push in cycle T:
  - `ram_re` in T+1.
  - Capture at the end of T+2.
  - `rd_pvld=1` in T+3.
- Throughput is 1 push and 1 pop per cycle in steady state. `out_cnt + inflight` never exceeds 2.
- Full: `ram_cnt=256` drives `wr_prdy=0` starting the cycle after the filling push. A simultaneous read in that cycle keeps `wr_prdy=1`.
- Empty: `ram_re=0`. `rd_pvld` stays high while the output stage is nonempty.
- Pointers wrap silently. Full and empty are decided by `ram_cnt` only.

## Configuration
- `NV_FIFO_CTRL_BYPASS_EN` defined:
  - A push goes directly into the output stage, bypassing the RAM, when `ram_cnt==0`, `inflight==0` and `out_cnt - pop < 2`.
  - `ram_we=0` for that push; `wr_adr` and `ram_cnt` are unchanged.
  - Empty-FIFO latency drops to 1: `rd_pvld` rises in T+1.
  - Capacity is still 258 and ordering is preserved.
- Macro undefined: every push goes through the RAM, with the latency given under Timing.

## Test plan
- Reset release with `wr_pvld=0` → `wr_prdy` is 0 in the first cycle and 1 from the first edge on. All outputs stay 0 and `fifo_cnt=0`.
- Single push of `0xA5` into an empty FIFO with `rd_prdy=1`:
  - macro off → `rd_pd=0xA5`, `rd_pvld` in T+3, `ram_wa=0`, `ram_ra=0`.
  - macro on → `rd_pvld` in T+1 and no `ram_we` pulse.
- Push 258 bytes 0..257 mod 256 with `rd_prdy=0` → `fifo_cnt=258` and `wr_prdy=0`. A 259th push is not accepted. Draining then returns the exact sequence, and `wr_prdy` returns to 1 the cycle after the first RAM read.
- Continuous push and pop for 1000 cycles with random data → no gaps once primed, `fifo_cnt` stays constant, pointers wrap past 255, and output matches input order.
- Random `wr_pvld` and `rd_prdy` at 50% → scoreboard matches. No cycle has `ram_re & ram_we & (ram_ra==ram_wa)`.
- Assert `nvdla_core_rstn` with `fifo_cnt=100` → outputs clear immediately. After release, the next push of `0x3C` is the first byte read out.
